// File: rtl/shift_arbiter.sv
// Round-robin two-port front end for the shared 32-bit shifter. Variable SLA
// is built from repeated 1-bit SLA passes; results return with the owner ID.
module shift_arbiter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_data,
    input  logic [4:0]   req0_amt,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_data,
    input  logic [4:0]   req1_amt,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         busy,
    output logic [W-1:0] sh_in,
    output logic [W-1:0] sh_rs2,
    output logic [4:0]   sh_shamt,
    output logic [2:0]   sh_func,
    input  logic [W-1:0] sh_out
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           rr_q, rr_d;
    logic [1:0]     op_q, op_d;
    logic           id_q, id_d;
    logic [4:0]     amt_q, amt_d;
    logic           rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_data_q, rsp_data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            rr_q       <= 1'b0;
            op_q       <= '0;
            id_q       <= 1'b0;
            amt_q      <= '0;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            op_q       <= op_d;
            id_q       <= id_d;
            amt_q      <= amt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        op_d       = op_q;
        id_d       = id_q;
        amt_d      = amt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        sh_func    = 3'b111;
        sh_in      = acc_q;
        sh_shamt   = '0;
        sh_rs2     = '0;

        case (state_q)
            IDLE: begin
                // rr_q breaks ties only; a lone valid is always granted
                if (req0_valid && (!req1_valid || !rr_q)) begin
                    req0_ready = 1'b1;
                    op_d       = req0_op;
                    id_d       = 1'b0;
                    amt_d      = req0_amt;
                    acc_d      = req0_data;
                    cnt_d      = req0_amt;
                    rr_d       = 1'b1;
                    state_d    = EXEC;
                end else if (req1_valid) begin
                    req1_ready = 1'b1;
                    op_d       = req1_op;
                    id_d       = 1'b1;
                    amt_d      = req1_amt;
                    acc_d      = req1_data;
                    cnt_d      = req1_amt;
                    rr_d       = 1'b0;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (op_q != 2'b11) begin
                    sh_func    = {1'b0, op_q};
                    sh_shamt   = amt_q;
                    rsp_data_d = sh_out;
                    rsp_id_d   = id_q;
                    state_d    = RESP;
                end else begin
                    sh_func = 3'b011;
                    sh_rs2  = {{(W-1){1'b0}}, 1'b1};
                    if (cnt_q == 5'd0) begin
                        rsp_data_d = acc_q;
                        rsp_id_d   = id_q;
                        state_d    = RESP;
                    end else begin
                        acc_d = sh_out;
                        cnt_d = cnt_q - 5'd1;
                        if (cnt_q == 5'd1) begin
                            rsp_data_d = sh_out;
                            rsp_id_d   = id_q;
                            state_d    = RESP;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural model of the shifter.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic        rsp_valid, rsp_id, busy;
    logic [31:0] rsp_data, sh_in, sh_rs2, sh_out;
    logic [4:0]  sh_shamt;
    logic [2:0]  sh_func;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_data(req1_data), .req1_amt(req1_amt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy),
        .sh_in(sh_in), .sh_rs2(sh_rs2), .sh_shamt(sh_shamt), .sh_func(sh_func),
        .sh_out(sh_out)
    );

    // Shifter model
    always_comb begin
        case (sh_func)
            3'b000:  sh_out = sh_in << sh_shamt;
            3'b001:  sh_out = sh_in >> sh_shamt;
            3'b010:  sh_out = $unsigned($signed(sh_in) >>> sh_shamt);
            3'b011:  sh_out = sh_in << sh_rs2[4:0];
            default: sh_out = sh_in;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first EXEC cycle.
    task automatic issue(input int port, input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] amt);
        if (port == 0) begin
            req0_valid = 1'b1; req0_op = op; req0_data = data; req0_amt = amt;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_data = data; req1_amt = amt;
        end
        #1;
        chk("ready_granted", port == 0 ? req0_ready : req1_ready, 1);
        chk("ready_both", {31'd0, req0_ready & req1_ready}, 0);
        @(negedge clk);
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    // Latency counted from the accept cycle T; entered in cycle T+1.
    task automatic wait_rsp(input int exp_lat, input logic exp_id, input logic [31:0] exp_data);
        int lat = 1;
        while (!rsp_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_valid", {31'd0, rsp_valid}, 1);
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_id});
        chk("rsp_data", rsp_data, exp_data);
        @(negedge clk);
        chk("rsp_valid_drop", {31'd0, rsp_valid}, 0);
        chk("rsp_data_hold", rsp_data, exp_data);
    endtask

    initial begin
        int lat;
        logic seen;
        rst_n = 1'b0;
        req0_valid = 0; req0_op = 0; req0_data = 0; req0_amt = 0;
        req1_valid = 0; req1_op = 0; req1_data = 0; req1_amt = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_sh_func", {29'd0, sh_func}, 3'b111);
        chk("rst_sh_in", sh_in, 0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both valid continuously: grants alternate 0,1,0,1
        req0_valid = 1; req0_op = 2'b00; req0_data = 32'd1; req0_amt = 5'd1;
        req1_valid = 1; req1_op = 2'b00; req1_data = 32'd2; req1_amt = 5'd1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            chk("rr_exec_ready", {30'd0, req1_ready, req0_ready}, 0);
            @(negedge clk);
            chk("rr_rsp_valid", {31'd0, rsp_valid}, 1);
            chk("rr_rsp_id", {31'd0, rsp_id}, i % 2);
            chk("rr_rsp_data", rsp_data, (i % 2 == 0) ? 32'd2 : 32'd4);
            chk("rr_resp_ready", {30'd0, req1_ready, req0_ready}, 0);
            @(negedge clk);
        end
        req0_valid = 0; req1_valid = 0;
        @(negedge clk);

        // SLL
        issue(0, 2'b00, 32'h0000_00F1, 5'd4);
        chk("sll_func", {29'd0, sh_func}, 3'b000);
        chk("sll_shamt", {27'd0, sh_shamt}, 4);
        chk("sll_busy", {31'd0, busy}, 1);
        chk("sll_exec_rsp_valid", {31'd0, rsp_valid}, 0);
        wait_rsp(2, 1'b0, 32'h0000_0F10);

        // SRA then SRL on requester 1
        issue(1, 2'b10, 32'h8000_0000, 5'd31);
        chk("sra_func", {29'd0, sh_func}, 3'b010);
        wait_rsp(2, 1'b1, 32'hFFFF_FFFF);
        issue(1, 2'b01, 32'h8000_0000, 5'd31);
        wait_rsp(2, 1'b1, 32'h0000_0001);

        // Variable SLA, amt 5 then amt 0
        issue(0, 2'b11, 32'h0000_0003, 5'd5);
        chk("sla_func", {29'd0, sh_func}, 3'b011);
        chk("sla_rs2", sh_rs2, 1);
        chk("sla_shamt", {27'd0, sh_shamt}, 0);
        wait_rsp(6, 1'b0, 32'h0000_0060);
        issue(0, 2'b11, 32'h0000_0003, 5'd0);
        wait_rsp(2, 1'b0, 32'h0000_0003);

        // req1 arrives during a long SLA and must wait
        issue(0, 2'b11, 32'h0000_0001, 5'd10);
        req1_valid = 1; req1_op = 2'b00; req1_data = 32'd5; req1_amt = 5'd2;
        lat = 1; seen = 1'b0;
        while (!rsp_valid && lat < 64) begin
            #1 seen |= req1_ready;
            @(negedge clk);
            lat++;
        end
        seen |= req1_ready;
        chk("wait_ready_low", {31'd0, seen}, 0);
        chk("wait_sla_latency", lat, 11);
        chk("wait_sla_data", rsp_data, 32'h0000_0400);
        @(negedge clk);
        #1 chk("wait_granted", {31'd0, req1_ready}, 1);
        @(negedge clk);
        req1_valid = 0;
        wait_rsp(2, 1'b1, 32'h0000_0014);

        // Reset on the third EXEC cycle of SLA amt 20
        issue(0, 2'b11, 32'h0000_0001, 5'd20);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("mid_rst_sh_func", {29'd0, sh_func}, 3'b111);
        chk("mid_rst_sh_in", sh_in, 0);
        chk("mid_rst_rsp_data", rsp_data, 0);
        chk("mid_rst_rsp_id", {31'd0, rsp_id}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            seen |= rsp_valid;
        end
        chk("post_rst_no_rsp", {31'd0, seen}, 0);
        issue(0, 2'b00, 32'h0000_1234, 5'd8);
        wait_rsp(2, 1'b0, 32'h0012_3400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
